// File: rtl/legv8_pkg.sv
// LEGv8 encoding constants shared by the program loader and decode.
// Op classes, opcodes, immediate widths, fixed words, error codes.
package legv8_pkg;

  localparam logic [3:0] OP_LDUR = 4'd0;
  localparam logic [3:0] OP_STUR = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_ADDI = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_ORR  = 4'd6;
  localparam logic [3:0] OP_CBZ  = 4'd7;
  localparam logic [3:0] OP_CBNZ = 4'd8;
  localparam logic [3:0] OP_B    = 4'd9;
  localparam logic [3:0] OP_HALT = 4'd10;
  localparam logic [3:0] OP_NOP  = 4'd11;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [7:0]  OPC_CBNZ = 8'b10110101;
  localparam logic [5:0]  OPC_B    = 6'b000101;

  localparam int IMM_W_I  = 12;
  localparam int IMM_W_D  = 9;
  localparam int IMM_W_CB = 19;
  localparam int IMM_W_B  = 26;

  localparam logic [31:0] HALT_WORD = {11'h7FF, 21'b0};
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_IMM  = 2'd1;
  localparam logic [1:0] ERR_FULL = 2'd2;
  localparam logic [1:0] ERR_OP   = 2'd3;

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [63:0] imm;
  } fields_t;

  // True when imm survives truncation to n bits and sign-extension back.
  function automatic logic imm_fits(input logic [63:0] imm, input int n);
    logic [63:0] hi;
    hi = $signed(imm) >>> (n - 1);
    return (hi == '0) || (&hi);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational LEGv8 packer: fields -> instruction word,
// plus immediate-range and op-class legality flags.
module instr_pack
  import legv8_pkg::*;
(
  input  fields_t     f,
  output logic [31:0] wdata,
  output logic        imm_ok,
  output logic        op_ok
);

  always_comb begin
    wdata  = NOP_WORD;
    imm_ok = 1'b1;
    op_ok  = 1'b1;
    unique case (f.op)
      OP_LDUR: begin
        wdata  = {OPC_LDUR, f.imm[8:0], 2'b00, f.rn, f.rd};
        imm_ok = imm_fits(f.imm, IMM_W_D);
      end
      OP_STUR: begin
        wdata  = {OPC_STUR, f.imm[8:0], 2'b00, f.rn, f.rd};
        imm_ok = imm_fits(f.imm, IMM_W_D);
      end
      OP_ADD:  wdata = {OPC_ADD, f.rm, 6'b0, f.rn, f.rd};
      OP_SUB:  wdata = {OPC_SUB, f.rm, 6'b0, f.rn, f.rd};
      OP_AND:  wdata = {OPC_AND, f.rm, 6'b0, f.rn, f.rd};
      OP_ORR:  wdata = {OPC_ORR, f.rm, 6'b0, f.rn, f.rd};
      OP_ADDI: begin
        wdata  = {OPC_ADDI, f.imm[11:0], f.rn, f.rd};
        imm_ok = imm_fits(f.imm, IMM_W_I);
      end
      OP_CBZ: begin
        wdata  = {OPC_CBZ, f.imm[18:0], f.rd};
        imm_ok = imm_fits(f.imm, IMM_W_CB);
      end
      OP_CBNZ: begin
        wdata  = {OPC_CBNZ, f.imm[18:0], f.rd};
        imm_ok = imm_fits(f.imm, IMM_W_CB);
      end
      OP_B: begin
        wdata  = {OPC_B, f.imm[25:0]};
        imm_ok = imm_fits(f.imm, IMM_W_B);
      end
      OP_HALT: wdata = HALT_WORD;
      OP_NOP:  wdata = NOP_WORD;
      default: op_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Boot/test program loader: packs field bundles into LEGv8 words
// and writes them to consecutive instruction-memory addresses.
module instr_encoder
  import legv8_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [63:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  localparam logic [ADDR_W-1:0] LAST   = '1;
  localparam logic [ADDR_W-1:0] A_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   C_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]  state;
  logic        is_halt;
  fields_t     f;
  logic [31:0] pw;
  logic        imm_ok;
  logic        op_ok;
  logic        accept;

  assign f = {in_op, in_rd, in_rn, in_rm, in_imm};

  instr_pack u_pack (
    .f      (f),
    .wdata  (pw),
    .imm_ok (imm_ok),
    .op_ok  (op_ok)
  );

  // Outputs decode straight from state so reset drops mem_we at once.
  assign in_ready = (state == S_IDLE);
  assign mem_we   = (state == S_WRITE);
  assign done     = (state == S_DONE);
  assign err      = (state == S_ERR);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err_code  <= ERR_NONE;
      count     <= '0;
      is_halt   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            if (!op_ok) begin
              state    <= S_ERR;
              err_code <= ERR_OP;
            end else if (!imm_ok) begin
              state    <= S_ERR;
              err_code <= ERR_IMM;
            end else begin
              state     <= S_WRITE;
              mem_wdata <= pw;
              is_halt   <= (in_op == OP_HALT);
            end
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            count <= count + C_ONE;
            if (is_halt) begin
              state <= S_DONE;
            end else if (mem_addr == LAST) begin
              state    <= S_ERR;
              err_code <= ERR_FULL;
            end else begin
              mem_addr <= mem_addr + A_ONE;
              state    <= S_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed table, hand
// sequences for stalls/full/reset, and randomized model checks.
module tb_instr_encoder;
  import legv8_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, in_valid, in_ready, mem_we, mem_ack;
  logic [3:0]  in_op;
  logic [4:0]  in_rd, in_rn, in_rm;
  logic [63:0] in_imm;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        done, err;
  logic [1:0]  err_code;
  logic [8:0]  count;

  logic        reset_n2, in_valid2, in_ready2, mem_we2, mem_ack2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata2;
  logic        done2, err2;
  logic [1:0]  err_code2;
  logic [2:0]  count2;

  instr_encoder #(.ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
    .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .done(done),
    .err(err), .err_code(err_code), .count(count)
  );

  instr_encoder #(.ADDR_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n2), .in_valid(in_valid2),
    .in_ready(in_ready2), .in_op(in_op), .in_rd(in_rd),
    .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
    .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_ack(mem_ack2), .done(done2),
    .err(err2), .err_code(err_code2), .count(count2)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int          op;
    int          rd;
    int          rn;
    int          rm;
    longint      imm;
    logic [31:0] w;
    int          code;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    mem_ack  = 1'b0;
    reset_n  = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!in_ready && k < 20) begin
      tick();
      k++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL ready_timeout: got in_ready=0 expected 1");
    end
  endtask

  task automatic send(input int op, input int rd, input int rn,
                      input int rm, input longint imm);
    wait_ready();
    in_op    = 4'(op);
    in_rd    = 5'(rd);
    in_rn    = 5'(rn);
    in_rm    = 5'(rm);
    in_imm   = 64'(imm);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic ack();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask

  // Reference encoder from the opcode table, using plain arithmetic.
  function automatic void ref_enc(input int op, input int rd,
                                  input int rn, input int rm,
                                  input longint imm,
                                  output logic [31:0] w,
                                  output int code);
    int     n;
    longint lim;
    longint fld;
    n    = 0;
    w    = 32'h0;
    code = 0;
    case (op)
      0:  begin n = 9;  w = 32'hF840_0000; end
      1:  begin n = 9;  w = 32'hF800_0000; end
      2:  w = 32'h8B00_0000;
      3:  begin n = 12; w = 32'h9100_0000; end
      4:  w = 32'hCB00_0000;
      5:  w = 32'h8A00_0000;
      6:  w = 32'hAA00_0000;
      7:  begin n = 19; w = 32'hB400_0000; end
      8:  begin n = 19; w = 32'hB500_0000; end
      9:  begin n = 26; w = 32'h1400_0000; end
      10: w = 32'hFFE0_0000;
      11: w = 32'h0000_0000;
      default: code = 3;
    endcase
    if (code == 0 && n > 0) begin
      lim = longint'(1) << (n - 1);
      if (imm < -lim || imm >= lim) code = 1;
    end
    if (code == 0) begin
      fld = (n > 0) ? (imm & ((longint'(1) << n) - 1)) : 0;
      case (op)
        0, 1:    w = w + 32'(fld * 4096 + rn * 32 + rd);
        2, 4, 5, 6:
                 w = w + 32'(rm * 65536 + rn * 32 + rd);
        3:       w = w + 32'(fld * 1024 + rn * 32 + rd);
        7, 8:    w = w + 32'(fld * 32 + rd);
        9:       w = w + 32'(fld);
        default: ;
      endcase
    end
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ew;
    int          ec;
    int          addr_m;
    int          cnt_m;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    mem_ack   = 1'b0;
    reset_n2  = 1'b0;
    in_valid2 = 1'b0;
    mem_ack2  = 1'b0;
    in_op = '0; in_rd = '0; in_rn = '0; in_rm = '0; in_imm = '0;
    do_reset();

    chk("rst_ready", in_ready, 1);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_count", count, 0);

    tv.push_back('{3, 1, 2, 0, -1, 32'h913FFC41, 0});
    tv.push_back('{0, 3, 4, 0, 255, 32'hF84FF083, 0});
    tv.push_back('{1, 5, 6, 0, -256, 32'hF81000C5, 0});
    tv.push_back('{2, 1, 2, 3, 64'h1234, 32'h8B030041, 0});
    tv.push_back('{4, 0, 0, 31, 0, 32'hCB1F0000, 0});
    tv.push_back('{6, 7, 8, 9, 0, 32'hAA090107, 0});
    tv.push_back('{7, 0, 0, 0, -4, 32'hB4FFFF80, 0});
    tv.push_back('{8, 31, 0, 0, 64'h3FFFF, 32'hB57FFFFF, 0});
    tv.push_back('{9, 0, 0, 0, 64'h1FFFFFF, 32'h15FFFFFF, 0});
    tv.push_back('{9, 0, 0, 0, -(64'sd1 <<< 25), 32'h16000000, 0});
    tv.push_back('{3, 0, 0, 0, -2048, 32'h91200000, 0});
    tv.push_back('{10, 0, 0, 0, 77, 32'hFFE00000, 0});
    tv.push_back('{11, 3, 3, 3, 77, 32'h00000000, 0});
    tv.push_back('{3, 0, 0, 0, 2048, 32'h0, 1});
    tv.push_back('{0, 0, 0, 0, 256, 32'h0, 1});
    tv.push_back('{0, 0, 0, 0, -257, 32'h0, 1});
    tv.push_back('{9, 0, 0, 0, 64'sd1 <<< 25, 32'h0, 1});
    tv.push_back('{12, 0, 0, 0, 0, 32'h0, 3});
    tv.push_back('{15, 0, 0, 0, 0, 32'h0, 3});

    foreach (tv[i]) begin
      do_reset();
      send(tv[i].op, tv[i].rd, tv[i].rn, tv[i].rm, tv[i].imm);
      if (tv[i].code != 0) begin
        chk($sformatf("v%0d_err", i), err, 1);
        chk($sformatf("v%0d_code", i), err_code, tv[i].code);
        chk($sformatf("v%0d_we", i), mem_we, 0);
        chk($sformatf("v%0d_ready", i), in_ready, 0);
        tick();
        chk($sformatf("v%0d_we2", i), mem_we, 0);
      end else begin
        chk($sformatf("v%0d_we", i), mem_we, 1);
        chk($sformatf("v%0d_wdata", i), mem_wdata, tv[i].w);
        chk($sformatf("v%0d_addr", i), mem_addr, 0);
        ack();
        chk($sformatf("v%0d_count", i), count, 1);
        chk($sformatf("v%0d_done", i), done, tv[i].op == 10);
        chk($sformatf("v%0d_ready", i), in_ready, tv[i].op != 10);
        chk($sformatf("v%0d_err", i), err, 0);
      end
    end

    // CBZ then B back to back at consecutive addresses.
    do_reset();
    send(7, 0, 0, 0, -4);
    chk("seq_addr0", mem_addr, 0);
    chk("seq_w0", mem_wdata, 32'hB4FFFF80);
    ack();
    send(9, 0, 0, 0, 64'h1FFFFFF);
    chk("seq_addr1", mem_addr, 1);
    chk("seq_w1", mem_wdata, 32'h15FFFFFF);
    ack();
    chk("seq_count", count, 2);

    // Stalled ack: outputs hold, new bundles ignored; then HALT.
    do_reset();
    send(2, 1, 2, 3, 0);
    in_op    = 4'(OP_SUB);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_we", mem_we, 1);
      chk("stall_addr", mem_addr, 0);
      chk("stall_wdata", mem_wdata, 32'h8B030041);
      chk("stall_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    ack();
    send(10, 0, 0, 0, 0);
    chk("halt_addr", mem_addr, 1);
    ack();
    chk("halt_done", done, 1);
    chk("halt_err", err, 0);
    chk("halt_ready", in_ready, 0);
    chk("halt_count", count, 2);
    mem_ack  = 1'b1;
    in_valid = 1'b1;
    tick();
    tick();
    mem_ack  = 1'b0;
    in_valid = 1'b0;
    chk("halt_sticky", done, 1);
    chk("halt_we", mem_we, 0);
    chk("halt_count2", count, 2);

    // Reset in the middle of a write.
    do_reset();
    send(3, 1, 1, 0, 5);
    ack();
    send(3, 1, 1, 0, 6);
    chk("mid_we_pre", mem_we, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_we", mem_we, 0);
    chk("mid_count", count, 0);
    chk("mid_addr", mem_addr, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("mid_ready", in_ready, 1);

    // Small memory fills up.
    reset_n2 = 1'b1;
    tick();
    in_op = 4'(OP_ADD);
    in_rd = 5'd1; in_rn = 5'd2; in_rm = 5'd3;
    for (int k = 0; k < 4; k++) begin
      chk("full_ready", in_ready2, 1);
      in_valid2 = 1'b1;
      tick();
      in_valid2 = 1'b0;
      chk("full_we", mem_we2, 1);
      chk("full_addr", mem_addr2, k);
      mem_ack2 = 1'b1;
      tick();
      mem_ack2 = 1'b0;
    end
    chk("full_err", err2, 1);
    chk("full_code", err_code2, 2);
    chk("full_addr_hold", mem_addr2, 3);
    chk("full_count", count2, 4);
    chk("full_ready_end", in_ready2, 0);
    chk("full_done", done2, 0);

    // Randomized traffic against the reference encoder.
    do_reset();
    addr_m = 0;
    cnt_m  = 0;
    for (int it = 0; it < 300; it++) begin
      int     r, op, dly;
      longint v;
      r = $urandom_range(0, 99);
      if (r < 3) op = 10;
      else if (r < 6) op = $urandom_range(12, 15);
      else begin
        op = $urandom_range(0, 10);
        if (op == 10) op = 11;
      end
      v = longint'({$urandom(), $urandom()});
      v = v >>> $urandom_range(0, 63);
      begin
        int rd, rn, rm;
        rd = $urandom_range(0, 31);
        rn = $urandom_range(0, 31);
        rm = $urandom_range(0, 31);
        ref_enc(op, rd, rn, rm, v, ew, ec);
        send(op, rd, rn, rm, v);
      end
      if (ec != 0) begin
        chk("rnd_err", err, 1);
        chk("rnd_code", err_code, ec);
        do_reset();
        addr_m = 0;
        cnt_m  = 0;
        continue;
      end
      chk("rnd_we", mem_we, 1);
      chk("rnd_wdata", mem_wdata, ew);
      chk("rnd_addr", mem_addr, addr_m);
      dly = $urandom_range(0, 3);
      for (int d = 0; d < dly; d++) tick();
      ack();
      cnt_m++;
      chk("rnd_count", count, cnt_m);
      if (op == 10) begin
        chk("rnd_done", done, 1);
        do_reset();
        addr_m = 0;
        cnt_m  = 0;
      end else if (addr_m == 255) begin
        chk("rnd_full", err_code, 2);
        do_reset();
        addr_m = 0;
        cnt_m  = 0;
      end else begin
        addr_m++;
        chk("rnd_ready", in_ready, 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
